c1_logic_cell: RTL and testbench
================================

Name: c1_logic_cell

Overview:
- Bitwise array of WIDTH ACT1-style "C1" combinational logic modules, i.e. a two-level 2:1 mux tree.
- Each bit lane selects one of four data inputs under three select inputs. Any 2- or 3-input Boolean function is configured by tying inputs to constants or signals; e.g. AND is A0=0, A1=a, SA=b, rest 0.
- Outputs are a combinational result plus a registered copy. Used as the primitive cell in gate-level datapath blocks (AND/OR/XOR, multiplier-accumulator).

Parameters:
- WIDTH, 1, number of independent bit lanes (≥1).

Ports:
- clk    input   1      rising-edge clock for the output register
- rst_n  input   1      asynchronous, active-low reset
- A0     input   WIDTH  upper-left mux data, selected when SA=0
- A1     input   WIDTH  upper-left mux data, selected when SA=1
- SA     input   WIDTH  select for the A mux
- B0     input   WIDTH  lower mux data, selected when SB=0
- B1     input   WIDTH  lower mux data, selected when SB=1
- SB     input   WIDTH  select for the B mux
- S0     input   WIDTH  final select term 0
- S1     input   WIDTH  final select term 1
- F      output  WIDTH  combinational cell output
- F_q    output  WIDTH  registered F

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Per lane i, evaluated independently:
  - mA = SA[i] ? A1[i] : A0[i]
  - mB = SB[i] ? B1[i] : B0[i]
  - F[i] = (S0[i] | S1[i]) ? mB : mA
- F is purely combinational, zero latency, and does not depend on clk or rst_n.
- F_q:
  - Captures F on every rising clk edge; latency 1 cycle.
  - rst_n low forces F_q to all-zeros immediately, without waiting for a clock edge.
  - F_q stays 0 while rst_n is low.
  - The first capture is at the first rising edge after rst_n deasserts.
- Reset mid-operation: F_q clears asynchronously; F keeps tracking its inputs.
- Select precedence: S0|S1 dominates; SA is don't-care when S0|S1=1, and SB is don't-care when S0|S1=0.
- No X-propagation special handling required beyond standard ternary semantics.
- No internal state other than the F_q register.

Optional Feature:
- Macro C1_HOLD_EN.
- Defined:
  - Adds input port en (1 bit, applies to all lanes).
  - F_q loads F only on rising edges where en=1, otherwise holds.
  - Reset still clears F_q asynchronously regardless of en.
  - F is unaffected by en.
- Undefined:
  - No en port.
  - F_q loads F every rising edge.

Decomposition:
- Shared package c1_pkg holds:
  - Constant C1_RESET_VAL = 0.
  - Localparam-style encodings of common configurations (AND, OR, XOR, NAND pin tie-offs) for use by wrapper cells.
- One natural sub-module: c1_mux2 (1-bit 2:1 mux).
  - Instantiated three times per lane: A mux, B mux, final mux with select S0|S1.
  - Lanes are replicated with a generate loop.

Test Plan:
- AND configuration (A0=0, A1=a, SA=b, rest 0), WIDTH=1, sweep (a,b) over 00,01,10,11 -> F = 0,0,0,1. F_q follows one cycle later.
- Exhaustive 256-vector sweep of the 8 inputs at WIDTH=1 -> F matches the reference equation for every vector. Key points:
  - S0=S1=0, SA=1, A1=1 -> F=1.
  - S1=1, SB=0, B0=1 -> F=1.
- Lane independence at WIDTH=4 with different selects per lane, e.g. SA=4'b1010, A1=4'b1111, A0=0, S0=S1=0 -> F=4'b1010.
- Async reset: F_q=1, assert rst_n=0 between clock edges -> F_q=0 immediately, while F still shows the combinational value. Deassert -> F_q updates at the next rising edge.
- C1_HOLD_EN defined: en=0 while F toggles 0→1 -> F_q holds its old value. en=1 -> F_q=1 after one edge. Reset with en=0 -> F_q=0.
- S0 and S1 both 1, SB=1, B1=0, B0=1, SA=1, A1=1 -> F=0 (B path wins, OR of selects).

Source files
------------

// File: rtl/c1_pkg.sv
// Shared constants for the C1 logic cell: reset value and pin tie-off
// encodings that wrapper cells use to build common two-input gates.
package c1_pkg;

  localparam logic C1_RESET_VAL = 1'b0;

  typedef enum logic [1:0] {
    C1_TIE_0 = 2'd0,
    C1_TIE_1 = 2'd1,
    C1_TIE_X = 2'd2,
    C1_TIE_Y = 2'd3
  } c1_tie_e;

  typedef struct packed {
    c1_tie_e a0;
    c1_tie_e a1;
    c1_tie_e sa;
    c1_tie_e b0;
    c1_tie_e b1;
    c1_tie_e sb;
    c1_tie_e s0;
    c1_tie_e s1;
  } c1_cfg_t;

  // F = x & y : A path passes x when y is high, B path unused
  localparam c1_cfg_t C1_CFG_AND  = '{C1_TIE_0, C1_TIE_X, C1_TIE_Y, C1_TIE_0,
                                      C1_TIE_0, C1_TIE_0, C1_TIE_0, C1_TIE_0};
  // F = x ? 1 : y
  localparam c1_cfg_t C1_CFG_OR   = '{C1_TIE_0, C1_TIE_1, C1_TIE_Y, C1_TIE_1,
                                      C1_TIE_1, C1_TIE_0, C1_TIE_X, C1_TIE_0};
  // F = y ? ~x : x
  localparam c1_cfg_t C1_CFG_XOR  = '{C1_TIE_0, C1_TIE_1, C1_TIE_X, C1_TIE_1,
                                      C1_TIE_0, C1_TIE_X, C1_TIE_Y, C1_TIE_0};
  // F = x ? ~y : 1
  localparam c1_cfg_t C1_CFG_NAND = '{C1_TIE_1, C1_TIE_1, C1_TIE_0, C1_TIE_1,
                                      C1_TIE_0, C1_TIE_Y, C1_TIE_X, C1_TIE_0};

  function automatic logic c1_tie(input c1_tie_e t, input logic x, input logic y);
    case (t)
      C1_TIE_0: c1_tie = 1'b0;
      C1_TIE_1: c1_tie = 1'b1;
      C1_TIE_X: c1_tie = x;
      default:  c1_tie = y;
    endcase
  endfunction

endpackage

// File: rtl/c1_mux2.sv
// Single-bit 2:1 multiplexer, the leaf element of the C1 mux tree.
module c1_mux2 (
  input  logic d0_i,
  input  logic d1_i,
  input  logic s_i,
  output logic y_o
);

  assign y_o = s_i ? d1_i : d0_i;

endmodule

// File: rtl/c1_logic_cell.sv
// WIDTH-lane array of ACT1-style C1 logic modules with a registered output.
// Optional macro C1_HOLD_EN adds a load enable (en) on the output register.
module c1_logic_cell
  import c1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef C1_HOLD_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] SA,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] B1,
  input  logic [WIDTH-1:0] SB,
  input  logic [WIDTH-1:0] S0,
  input  logic [WIDTH-1:0] S1,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] F_q
);

  logic [WIDTH-1:0] fq_d;
  logic [WIDTH-1:0] fq_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic ma;
    logic mb;

    c1_mux2 u_mux_a (.d0_i(A0[i]), .d1_i(A1[i]), .s_i(SA[i]), .y_o(ma));
    c1_mux2 u_mux_b (.d0_i(B0[i]), .d1_i(B1[i]), .s_i(SB[i]), .y_o(mb));
    // Either final select term routes the B path through
    c1_mux2 u_mux_f (.d0_i(ma), .d1_i(mb), .s_i(S0[i] | S1[i]), .y_o(F[i]));
  end

  always_comb begin
    fq_d = fq_q;
`ifdef C1_HOLD_EN
    if (en) fq_d = F;
`else
    fq_d = F;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fq_q <= {WIDTH{C1_RESET_VAL}};
    else        fq_q <= fq_d;
  end

  assign F_q = fq_q;

endmodule

// File: tb/tb_c1_logic_cell.sv
// Scoreboard bench for c1_logic_cell: a WIDTH=1 and a WIDTH=4 instance share stimulus.
module tb_c1_logic_cell;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] a0, a1, sa, b0, b1, sb, s0, s1;
  logic [0:0] f1, fq1;
  logic [3:0] f4, fq4;

  c1_logic_cell #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef C1_HOLD_EN
    .en(en),
`endif
    .A0(a0[0]), .A1(a1[0]), .SA(sa[0]), .B0(b0[0]), .B1(b1[0]), .SB(sb[0]),
    .S0(s0[0]), .S1(s1[0]), .F(f1), .F_q(fq1)
  );

  c1_logic_cell #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
`ifdef C1_HOLD_EN
    .en(en),
`endif
    .A0(a0), .A1(a1), .SA(sa), .B0(b0), .B1(b1), .SB(sb),
    .S0(s0), .S1(s1), .F(f4), .F_q(fq4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      tag;
    logic [3:0] f;
    logic [3:0] fq;
  } exp_t;

  exp_t       sbq[$];
  event       smp;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] prev_f = 4'h0;

  task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per sample strobe and checks both instances
  initial begin
    exp_t e;
    forever begin
      @(smp);
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_underflow: got empty queue expected an entry");
      end else begin
        e = sbq.pop_front();
        cmp({e.tag, "_F4"},  f4,  e.f);
        cmp({e.tag, "_Fq4"}, fq4, e.fq);
        cmp({e.tag, "_F1"},  {3'b000, f1},  {3'b000, e.f[0]});
        cmp({e.tag, "_Fq1"}, {3'b000, fq1}, {3'b000, e.fq[0]});
      end
    end
  end

  task automatic expect_now(input string tag, input logic [3:0] ef, input logic [3:0] efq);
    exp_t e;
    e.tag = tag;
    e.f   = ef;
    e.fq  = efq;
    sbq.push_back(e);
    ->smp;
  endtask

  task automatic drive(input logic [3:0] va0, va1, vsa, vb0, vb1, vsb, vs0, vs1);
    a0 = va0; a1 = va1; sa = vsa; b0 = vb0;
    b1 = vb1; sb = vsb; s0 = vs0; s1 = vs1;
  endtask

  // Drive after a rising edge, check at the following falling edge
  task automatic vecx(input string tag, input logic [3:0] va0, va1, vsa, vb0, vb1, vsb,
                      vs0, vs1, input logic [3:0] ef, input logic [3:0] efq);
    @(posedge clk);
    #2;
    drive(va0, va1, vsa, vb0, vb1, vsb, vs0, vs1);
    @(negedge clk);
    expect_now(tag, ef, efq);
    prev_f = ef;
  endtask

  task automatic vec(input string tag, input logic [3:0] va0, va1, vsa, vb0, vb1, vsb,
                     vs0, vs1, input logic [3:0] ef);
    vecx(tag, va0, va1, vsa, vb0, vb1, vsb, vs0, vs1, ef, prev_f);
  endtask

  function automatic logic [3:0] ref4(input logic [3:0] va0, va1, vsa, vb0, vb1, vsb, vs0, vs1);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) begin
      r[k] = ((vs0[k] | vs1[k]) & ((vsb[k] & vb1[k]) | (~vsb[k] & vb0[k]))) |
             (~(vs0[k] | vs1[k]) & ((vsa[k] & va1[k]) | (~vsa[k] & va0[k])));
    end
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    drive('0, '0, '0, '0, '0, '0, '0, '0);
    #3;
    drive(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    #1;
    expect_now("reset", 4'hF, 4'h0);
    #4;
    drive('0, '0, '0, '0, '0, '0, '0, '0);
    #9;
    rst_n = 1'b1;

    // AND tie-off sweep, lanes replicated: (a,b) = 00,01,10,11
    vec("and00", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vec("and01", 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vec("and10", 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vec("and11", 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
    vec("and_ln", 4'h0, 4'b1100, 4'b1010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1000);

    // Lane independence
    vec("lane_a", 4'h0, 4'hF, 4'b1010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1010);
    vec("lane_mix", 4'b1100, 4'h0, 4'h0, 4'h0, 4'hF, 4'b0101, 4'b0011, 4'h0, 4'b1101);

    // Select precedence corners
    vec("sa_path", 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
    vec("s1_b0",   4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF);
    vec("s01_b1",  4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0);

    // Exhaustive sweep of the eight inputs
    for (int v = 0; v < 256; v++) begin
      logic [7:0] bv;
      logic [3:0] t0, t1, t2, t3, t4, t5, t6, t7;
      bv = v[7:0];
      t0 = {4{bv[0]}}; t1 = {4{bv[1]}}; t2 = {4{bv[2]}}; t3 = {4{bv[3]}};
      t4 = {4{bv[4]}}; t5 = {4{bv[5]}}; t6 = {4{bv[6]}}; t7 = {4{bv[7]}};
      vec($sformatf("ex%0d", v), t0, t1, t2, t3, t4, t5, t6, t7,
          ref4(t0, t1, t2, t3, t4, t5, t6, t7));
    end

    // Asynchronous reset mid-operation
    vec("pre_rst0", 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
    vec("pre_rst1", 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    expect_now("rst_async", 4'hF, 4'h0);
    @(posedge clk);
    #4;
    expect_now("rst_hold", 4'hF, 4'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    expect_now("rst_rel", 4'hF, 4'h0);
    @(posedge clk);
    #1;
    expect_now("rst_cap", 4'hF, 4'hF);
    prev_f = 4'hF;

`ifdef C1_HOLD_EN
    vec("hold_z0", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vec("hold_z1", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    en = 1'b0;
    vecx("hold_t0", 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0);
    vecx("hold_t1", 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0);
    en = 1'b1;
    vecx("hold_ld", 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("hold_rst", 4'hF, 4'h0);
    #2;
    rst_n = 1'b1;
    en = 1'b1;
    prev_f = 4'hF;
    @(posedge clk);
    #1;
    expect_now("hold_rel", 4'hF, 4'hF);
`endif

    @(negedge clk);
    n_vec++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
